// File: rtl/softex_pkg.sv
// Shared types for the softex slot cache: slot contents, request/update ops,
// response record and slot-manager FSM states.
package softex_pkg;

  localparam int unsigned SLOT_ADDR_BITS  = 8;
  localparam int unsigned N_SLOTS_DEFAULT = 8;

  typedef struct packed {
    logic [15:0] maximum;
    logic [31:0] denominator;
    logic        valid;
  } slot_t;

  typedef enum logic {SLOT_ALLOC, SLOT_LOAD} slot_req_kind_e;
  typedef enum logic {SLOT_UPDATE, SLOT_FREE} slot_upd_kind_e;

  typedef struct packed {
    slot_req_kind_e            op;
    logic [SLOT_ADDR_BITS-1:0] addr;
  } slot_req_op_t;

  typedef struct packed {
    slot_upd_kind_e            op;
    logic [SLOT_ADDR_BITS-1:0] addr;
    logic [15:0]               maximum;
    logic [31:0]               denominator;
  } slot_update_op_t;

  typedef struct packed {
    logic [SLOT_ADDR_BITS-1:0] addr;
    slot_t                     slot;
    logic                      err;
  } slot_rsp_t;

  typedef enum logic {IDLE, RESP} slot_mgr_state_e;

endpackage

// File: rtl/softex_slot_manager_if.sv
// Request/response and update handshake bundle of the softex slot manager.
interface softex_slot_manager_if import softex_pkg::*; #(
  parameter int unsigned ADDR_W = SLOT_ADDR_BITS
);
  logic              req_valid_i;
  logic              req_ready_o;
  slot_req_op_t      req_op_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [ADDR_W-1:0] rsp_addr_o;
  slot_t             rsp_slot_o;
  logic              rsp_err_o;
  logic              upd_valid_i;
  logic              upd_ready_o;
  slot_update_op_t   upd_op_i;
  logic              upd_err_o;

  modport slave (
    input  req_valid_i, req_op_i, rsp_ready_i, upd_valid_i, upd_op_i,
    output req_ready_o, rsp_valid_o, rsp_addr_o, rsp_slot_o, rsp_err_o,
           upd_ready_o, upd_err_o
  );

  modport master (
    output req_valid_i, req_op_i, rsp_ready_i, upd_valid_i, upd_op_i,
    input  req_ready_o, rsp_valid_o, rsp_addr_o, rsp_slot_o, rsp_err_o,
           upd_ready_o, upd_err_o
  );
endinterface

// File: rtl/softex_slot_free_picker.sv
// Combinational lowest-index free-slot encoder over the alloc vector.
module softex_slot_free_picker #(
  parameter int unsigned N_SLOTS = 8,
  parameter int unsigned ADDR_W  = 8
) (
  input  logic [N_SLOTS-1:0] i_alloc,
  output logic [ADDR_W-1:0]  o_idx,
  output logic               o_none_free
);
  logic w_found;

  always_comb begin
    o_idx   = '0;
    w_found = 1'b0;
    for (int unsigned i = 0; i < N_SLOTS; i++) begin
      if (!i_alloc[i] && !w_found) begin
        o_idx   = ADDR_W'(i);
        w_found = 1'b1;
      end
    end
    o_none_free = !w_found;
  end
endmodule

// File: rtl/softex_slot_manager.sv
// Softmax state-slot cache controller: ALLOC/LOAD requests, UPDATE/FREE writebacks.
// Optional macro SOFTEX_SLOT_FWD_EN forwards a same-cycle update to a LOAD.
module softex_slot_manager import softex_pkg::*; #(
  parameter  int unsigned N_SLOTS = N_SLOTS_DEFAULT,
  parameter  int unsigned ADDR_W  = SLOT_ADDR_BITS,
  localparam int unsigned NFW     = $clog2(N_SLOTS + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  softex_slot_manager_if.slave   bus,
  output logic                   busy_o,
  output logic [NFW-1:0]         n_free_o
);
  slot_mgr_state_e    r_state, w_state_nxt;
  logic [N_SLOTS-1:0] r_alloc, w_alloc_nxt;
  slot_t              r_slot     [N_SLOTS];
  slot_t              w_slot_nxt [N_SLOTS];
  slot_rsp_t          r_rsp, w_rsp_nxt;
  logic               r_upd_err;
  logic [NFW-1:0]     r_n_free, w_n_free_nxt;

  logic               w_req_acc, w_upd_acc, w_upd_ok, w_ld_alloc, w_alloc_go, w_none_free;
  logic [ADDR_W-1:0]  w_free_idx;
  logic [N_SLOTS-1:0] w_upd_sel, w_ld_sel, w_alloc_sel;
  slot_t              w_ld_slot;

  softex_slot_free_picker #(.N_SLOTS(N_SLOTS), .ADDR_W(ADDR_W)) u_picker (
    .i_alloc     (r_alloc),
    .o_idx       (w_free_idx),
    .o_none_free (w_none_free)
  );

  always_comb begin
    w_state_nxt     = r_state;
    bus.req_ready_o = 1'b0;
    bus.rsp_valid_o = 1'b0;
    case (r_state)
      IDLE: begin
        bus.req_ready_o = !clear_i;
        if (bus.req_valid_i && !clear_i) w_state_nxt = RESP;
      end
      RESP: begin
        bus.rsp_valid_o = 1'b1;
        if (bus.rsp_ready_i) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (clear_i) w_state_nxt = IDLE;
  end

  // Address decode by comparison, so out-of-range addresses select nothing.
  always_comb begin
    w_ld_slot = '0;
    for (int unsigned i = 0; i < N_SLOTS; i++) begin
      w_upd_sel[i]   = bus.upd_op_i.addr == SLOT_ADDR_BITS'(i);
      w_ld_sel[i]    = bus.req_op_i.addr == SLOT_ADDR_BITS'(i);
      w_alloc_sel[i] = w_free_idx == ADDR_W'(i);
      if (w_ld_sel[i]) w_ld_slot = r_slot[i];
    end
    w_req_acc  = bus.req_valid_i && bus.req_ready_o;
    w_upd_acc  = bus.upd_valid_i && !clear_i;
    w_upd_ok   = |(w_upd_sel & r_alloc);
    w_ld_alloc = |(w_ld_sel & r_alloc);
    w_alloc_go = w_req_acc && bus.req_op_i.op == SLOT_ALLOC && !w_none_free;
  end

  always_comb begin
    w_rsp_nxt = r_rsp;
    if (w_req_acc) begin
      if (bus.req_op_i.op == SLOT_ALLOC) begin
        w_rsp_nxt.addr = w_none_free ? '0 : SLOT_ADDR_BITS'(w_free_idx);
        w_rsp_nxt.slot = '0;
        w_rsp_nxt.err  = w_none_free;
      end else begin
        w_rsp_nxt.addr = bus.req_op_i.addr;
        w_rsp_nxt.slot = w_ld_alloc ? w_ld_slot : '0;
        w_rsp_nxt.err  = !w_ld_alloc;
`ifdef SOFTEX_SLOT_FWD_EN
        if (w_ld_alloc && w_upd_acc && w_upd_ok && bus.upd_op_i.addr == bus.req_op_i.addr) begin
          if (bus.upd_op_i.op == SLOT_UPDATE) begin
            w_rsp_nxt.slot = '{maximum: bus.upd_op_i.maximum,
                               denominator: bus.upd_op_i.denominator, valid: 1'b1};
          end else begin
            w_rsp_nxt.slot = '0;
            w_rsp_nxt.err  = 1'b1;
          end
        end
`endif
      end
    end
    if (clear_i) w_rsp_nxt = '0;
  end

  // ALLOC only targets free slots and updates only allocated ones, so they never collide.
  always_comb begin
    w_alloc_nxt  = r_alloc;
    w_slot_nxt   = r_slot;
    w_n_free_nxt = '0;
    for (int unsigned i = 0; i < N_SLOTS; i++) begin
      if (w_upd_acc && w_upd_sel[i] && r_alloc[i]) begin
        if (bus.upd_op_i.op == SLOT_UPDATE) begin
          w_slot_nxt[i] = '{maximum: bus.upd_op_i.maximum,
                            denominator: bus.upd_op_i.denominator, valid: 1'b1};
        end else begin
          w_alloc_nxt[i]      = 1'b0;
          w_slot_nxt[i].valid = 1'b0;
        end
      end
      if (w_alloc_go && w_alloc_sel[i]) begin
        w_alloc_nxt[i] = 1'b1;
        w_slot_nxt[i]  = '0;
      end
      if (clear_i) begin
        w_alloc_nxt[i] = 1'b0;
        w_slot_nxt[i]  = '0;
      end
      w_n_free_nxt = w_n_free_nxt + NFW'(!w_alloc_nxt[i]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_alloc   <= '0;
      r_rsp     <= '0;
      r_upd_err <= 1'b0;
      r_n_free  <= NFW'(N_SLOTS);
      for (int unsigned i = 0; i < N_SLOTS; i++) r_slot[i] <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_alloc   <= w_alloc_nxt;
      r_rsp     <= w_rsp_nxt;
      r_upd_err <= w_upd_acc && !w_upd_ok;
      r_n_free  <= w_n_free_nxt;
      for (int unsigned i = 0; i < N_SLOTS; i++) r_slot[i] <= w_slot_nxt[i];
    end
  end

  assign bus.rsp_addr_o  = ADDR_W'(r_rsp.addr);
  assign bus.rsp_slot_o  = r_rsp.slot;
  assign bus.rsp_err_o   = r_rsp.err;
  assign bus.upd_ready_o = !clear_i;
  assign bus.upd_err_o   = r_upd_err;
  assign busy_o          = r_state != IDLE;
  assign n_free_o        = r_n_free;
endmodule

// File: tb/tb_softex_slot_manager.sv
// Self-checking bench for softex_slot_manager: directed scenarios plus random
// traffic against a slot-array reference model.
module tb_softex_slot_manager;
  import softex_pkg::*;

  localparam int unsigned NS = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       busy;
  logic [3:0] n_free;
  int         total = 0;
  int         bad = 0;

  softex_slot_manager_if #(.ADDR_W(SLOT_ADDR_BITS)) bus ();

  softex_slot_manager #(.N_SLOTS(NS), .ADDR_W(SLOT_ADDR_BITS)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .clear_i  (clear),
    .bus      (bus.slave),
    .busy_o   (busy),
    .n_free_o (n_free)
  );

  always #5 clk = ~clk;

  // Reference model: slot array plus one pending response.
  bit        m_alloc [NS];
  slot_t     m_slot  [NS];
  bit        m_pend;
  slot_rsp_t m_rsp;
  bit        m_upd_err;

  function automatic void model_reset();
    for (int i = 0; i < NS; i++) begin m_alloc[i] = 0; m_slot[i] = '0; end
    m_pend = 0; m_rsp = '0; m_upd_err = 0;
  endfunction

  function automatic int model_free();
    int n = 0;
    for (int i = 0; i < NS; i++) if (!m_alloc[i]) n++;
    return n;
  endfunction

  function automatic void model_edge();
    int  ua, la, pick;
    bit  req_acc, uok;
    if (clear) begin model_reset(); return; end
    ua = int'(bus.upd_op_i.addr);
    la = int'(bus.req_op_i.addr);
    req_acc = bus.req_valid_i && !m_pend;
    uok = bus.upd_valid_i && ua < NS && m_alloc[ua];
    if (m_pend && bus.rsp_ready_i) m_pend = 0;
    pick = -1;
    for (int i = NS - 1; i >= 0; i--) if (!m_alloc[i]) pick = i;
    if (req_acc) begin
      m_pend = 1;
      if (bus.req_op_i.op == SLOT_ALLOC) begin
        m_rsp.addr = (pick < 0) ? '0 : 8'(pick);
        m_rsp.slot = '0;
        m_rsp.err  = pick < 0;
      end else begin
        m_rsp.addr = bus.req_op_i.addr;
        if (la < NS && m_alloc[la]) begin
          m_rsp.slot = m_slot[la]; m_rsp.err = 0;
`ifdef SOFTEX_SLOT_FWD_EN
          if (uok && ua == la) begin
            if (bus.upd_op_i.op == SLOT_UPDATE)
              m_rsp.slot = '{bus.upd_op_i.maximum, bus.upd_op_i.denominator, 1'b1};
            else begin m_rsp.slot = '0; m_rsp.err = 1; end
          end
`endif
        end else begin
          m_rsp.slot = '0; m_rsp.err = 1;
        end
      end
    end
    if (uok) begin
      if (bus.upd_op_i.op == SLOT_UPDATE)
        m_slot[ua] = '{bus.upd_op_i.maximum, bus.upd_op_i.denominator, 1'b1};
      else begin m_alloc[ua] = 0; m_slot[ua].valid = 0; end
    end
    if (req_acc && bus.req_op_i.op == SLOT_ALLOC && pick >= 0) begin
      m_alloc[pick] = 1; m_slot[pick] = '0;
    end
    m_upd_err = bus.upd_valid_i && !uok;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_req(input bit v, input slot_req_kind_e op, input int addr);
    bus.req_valid_i = v; bus.req_op_i.op = op; bus.req_op_i.addr = 8'(addr);
  endtask

  task automatic set_upd(input bit v, input slot_upd_kind_e op, input int addr,
                         input logic [15:0] mx, input logic [31:0] dn);
    bus.upd_valid_i = v; bus.upd_op_i.op = op; bus.upd_op_i.addr = 8'(addr);
    bus.upd_op_i.maximum = mx; bus.upd_op_i.denominator = dn;
  endtask

  task automatic do_alloc();
    set_req(1, SLOT_ALLOC, 0); tick(); set_req(0, SLOT_ALLOC, 0); tick();
  endtask

  task automatic test_reset();
    total++; if (bus.req_ready_o !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%0b exp=1", bus.req_ready_o); end
    total++; if (bus.rsp_valid_o !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%0b exp=0", bus.rsp_valid_o); end
    total++; if (bus.rsp_addr_o !== 8'd0 || bus.rsp_slot_o !== '0 || bus.rsp_err_o !== 1'b0) begin
      bad++; $display("FAIL reset_rsp got addr=%0h slot=%0h err=%0b exp=0", bus.rsp_addr_o, bus.rsp_slot_o, bus.rsp_err_o); end
    total++; if (bus.upd_err_o !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_flags got upd_err=%0b busy=%0b exp=0", bus.upd_err_o, busy); end
    total++; if (n_free !== 4'd8) begin bad++; $display("FAIL reset_n_free got=%0d exp=8", n_free); end
  endtask

  task automatic test_alloc_fill();
    for (int k = 0; k < 9; k++) begin
      set_req(1, SLOT_ALLOC, 0); tick(); set_req(0, SLOT_ALLOC, 0);
      total++;
      if (bus.rsp_valid_o !== 1'b1 || bus.req_ready_o !== 1'b0 || busy !== 1'b1) begin
        bad++; $display("FAIL alloc_fill_hs k=%0d got valid=%0b ready=%0b busy=%0b exp 1/0/1", k, bus.rsp_valid_o, bus.req_ready_o, busy); end
      total++;
      if (k < 8 && (bus.rsp_addr_o !== 8'(k) || bus.rsp_err_o !== 1'b0 || n_free !== 4'(7 - k))) begin
        bad++; $display("FAIL alloc_fill k=%0d got addr=%0d err=%0b n_free=%0d exp addr=%0d err=0 n_free=%0d",
                        k, bus.rsp_addr_o, bus.rsp_err_o, n_free, k, 7 - k); end
      else if (k == 8 && (bus.rsp_addr_o !== 8'd0 || bus.rsp_err_o !== 1'b1 || n_free !== 4'd0)) begin
        bad++; $display("FAIL alloc_full got addr=%0d err=%0b n_free=%0d exp addr=0 err=1 n_free=0", bus.rsp_addr_o, bus.rsp_err_o, n_free); end
      tick();
    end
    clear = 1; tick(); clear = 0;
  endtask

  task automatic test_update_load();
    do_alloc();
    set_upd(1, SLOT_UPDATE, 0, 16'h3F80, 32'h4000_0000); tick(); set_upd(0, SLOT_UPDATE, 0, '0, '0);
    set_req(1, SLOT_LOAD, 0); tick(); set_req(0, SLOT_LOAD, 0);
    total++;
    if (bus.rsp_slot_o !== slot_t'({16'h3F80, 32'h4000_0000, 1'b1}) || bus.rsp_err_o !== 1'b0) begin
      bad++; $display("FAIL update_load got slot=%0h err=%0b exp slot=%0h err=0", bus.rsp_slot_o, bus.rsp_err_o,
                      slot_t'({16'h3F80, 32'h4000_0000, 1'b1})); end
    tick();
  endtask

  task automatic test_fwd();
    slot_t exp;
    do_alloc(); do_alloc(); do_alloc();
    set_upd(1, SLOT_UPDATE, 3, 16'h1111, 32'h1234_5678); tick();
    set_upd(1, SLOT_UPDATE, 3, 16'h2222, 32'h3F80_0000);
    set_req(1, SLOT_LOAD, 3); tick();
    set_req(0, SLOT_LOAD, 0); set_upd(0, SLOT_UPDATE, 0, '0, '0);
`ifdef SOFTEX_SLOT_FWD_EN
    exp = '{16'h2222, 32'h3F80_0000, 1'b1};
`else
    exp = '{16'h1111, 32'h1234_5678, 1'b1};
`endif
    total++;
    if (bus.rsp_slot_o !== exp || bus.rsp_err_o !== 1'b0) begin
      bad++; $display("FAIL load_upd_same got slot=%0h err=%0b exp slot=%0h err=0", bus.rsp_slot_o, bus.rsp_err_o, exp); end
    tick();
    set_req(1, SLOT_LOAD, 3); tick(); set_req(0, SLOT_LOAD, 0);
    exp = '{16'h2222, 32'h3F80_0000, 1'b1};
    total++;
    if (bus.rsp_slot_o !== exp) begin
      bad++; $display("FAIL load_after_upd got slot=%0h exp=%0h", bus.rsp_slot_o, exp); end
    tick();
  endtask

  task automatic test_free_alloc_same_cycle();
    for (int k = 0; k < 4; k++) do_alloc();
    total++; if (n_free !== 4'd0) begin bad++; $display("FAIL full_n_free got=%0d exp=0", n_free); end
    set_upd(1, SLOT_FREE, 2, '0, '0); set_req(1, SLOT_ALLOC, 0); tick();
    set_upd(0, SLOT_FREE, 0, '0, '0); set_req(0, SLOT_ALLOC, 0);
    total++;
    if (bus.rsp_err_o !== 1'b1 || n_free !== 4'd1 || bus.upd_err_o !== 1'b0) begin
      bad++; $display("FAIL free_alloc_same got err=%0b n_free=%0d upd_err=%0b exp err=1 n_free=1 upd_err=0",
                      bus.rsp_err_o, n_free, bus.upd_err_o); end
    tick();
    set_req(1, SLOT_ALLOC, 0); tick(); set_req(0, SLOT_ALLOC, 0);
    total++;
    if (bus.rsp_addr_o !== 8'd2 || bus.rsp_err_o !== 1'b0 || n_free !== 4'd0) begin
      bad++; $display("FAIL alloc_retry got addr=%0d err=%0b n_free=%0d exp addr=2 err=0 n_free=0", bus.rsp_addr_o, bus.rsp_err_o, n_free); end
    tick();
  endtask

  task automatic test_backpressure_clear();
    slot_t exp = '{16'h3F80, 32'h4000_0000, 1'b1};
    bus.rsp_ready_i = 0;
    set_req(1, SLOT_LOAD, 0); tick();
    for (int k = 0; k < 5; k++) begin
      tick();
      total++;
      if (bus.rsp_valid_o !== 1'b1 || bus.req_ready_o !== 1'b0 || bus.rsp_addr_o !== 8'd0 ||
          bus.rsp_slot_o !== exp || bus.rsp_err_o !== 1'b0) begin
        bad++; $display("FAIL stall k=%0d got valid=%0b ready=%0b addr=%0d slot=%0h err=%0b exp 1/0/0/%0h/0",
                        k, bus.rsp_valid_o, bus.req_ready_o, bus.rsp_addr_o, bus.rsp_slot_o, bus.rsp_err_o, exp); end
    end
    clear = 1; set_upd(1, SLOT_UPDATE, 1, 16'h5555, 32'h5555); #1;
    total++;
    if (bus.req_ready_o !== 1'b0 || bus.upd_ready_o !== 1'b0) begin
      bad++; $display("FAIL clear_readies got req=%0b upd=%0b exp 0/0", bus.req_ready_o, bus.upd_ready_o); end
    tick();
    total++;
    if (bus.rsp_valid_o !== 1'b0 || n_free !== 4'd8 || busy !== 1'b0 || bus.upd_err_o !== 1'b0) begin
      bad++; $display("FAIL after_clear got valid=%0b n_free=%0d busy=%0b upd_err=%0b exp 0/8/0/0",
                      bus.rsp_valid_o, n_free, busy, bus.upd_err_o); end
    clear = 0; set_req(0, SLOT_LOAD, 0); set_upd(0, SLOT_UPDATE, 0, '0, '0); bus.rsp_ready_i = 1;
    tick();
  endtask

  task automatic test_upd_errors();
    do_alloc();
    set_upd(1, SLOT_UPDATE, 5, 16'hAAAA, 32'hBBBB); tick();
    total++; if (bus.upd_err_o !== 1'b1) begin bad++; $display("FAIL upd_unalloc got=%0b exp=1", bus.upd_err_o); end
    set_upd(1, SLOT_FREE, 200, '0, '0); tick();
    total++; if (bus.upd_err_o !== 1'b1) begin bad++; $display("FAIL free_oor got=%0b exp=1", bus.upd_err_o); end
    set_upd(0, SLOT_FREE, 0, '0, '0); tick();
    total++;
    if (bus.upd_err_o !== 1'b0 || n_free !== 4'd7) begin
      bad++; $display("FAIL upd_err_clear got upd_err=%0b n_free=%0d exp 0/7", bus.upd_err_o, n_free); end
    set_req(1, SLOT_LOAD, 5); tick(); set_req(0, SLOT_LOAD, 0);
    total++;
    if (bus.rsp_err_o !== 1'b1 || bus.rsp_slot_o !== '0) begin
      bad++; $display("FAIL load_unalloc got err=%0b slot=%0h exp err=1 slot=0", bus.rsp_err_o, bus.rsp_slot_o); end
    tick();
  endtask

  task automatic test_async_reset();
    bus.rsp_ready_i = 0;
    set_req(1, SLOT_LOAD, 0); tick(); set_req(0, SLOT_LOAD, 0);
    #2 rst_n = 0; #1;
    model_reset();
    total++;
    if (bus.rsp_valid_o !== 1'b0 || busy !== 1'b0 || n_free !== 4'd8 || bus.rsp_err_o !== 1'b0) begin
      bad++; $display("FAIL async_reset got valid=%0b busy=%0b n_free=%0d err=%0b exp 0/0/8/0",
                      bus.rsp_valid_o, busy, n_free, bus.rsp_err_o); end
    bus.rsp_ready_i = 1;
    #2 rst_n = 1;
    tick();
    total++; if (bus.rsp_valid_o !== 1'b0) begin bad++; $display("FAIL no_replay got valid=%0b exp=0", bus.rsp_valid_o); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      clear = ($urandom_range(0, 49) == 0);
      set_req($urandom_range(0, 1) == 1, slot_req_kind_e'($urandom_range(0, 1)), $urandom_range(0, 9));
      set_upd($urandom_range(0, 1) == 1, slot_upd_kind_e'($urandom_range(0, 1)), $urandom_range(0, 9),
              16'($urandom), $urandom);
      bus.rsp_ready_i = ($urandom_range(0, 9) < 7);
      tick();
      total++;
      if (bus.rsp_valid_o !== m_pend || busy !== m_pend || bus.req_ready_o !== (!m_pend && !clear) ||
          bus.upd_ready_o !== !clear) begin
        bad++; $display("FAIL rnd_hs c=%0d got valid=%0b busy=%0b rdy=%0b urdy=%0b exp pend=%0b clear=%0b",
                        c, bus.rsp_valid_o, busy, bus.req_ready_o, bus.upd_ready_o, m_pend, clear); end
      total++;
      if (m_pend && (bus.rsp_addr_o !== m_rsp.addr || bus.rsp_slot_o !== m_rsp.slot || bus.rsp_err_o !== m_rsp.err)) begin
        bad++; $display("FAIL rnd_rsp c=%0d got addr=%0d slot=%0h err=%0b exp addr=%0d slot=%0h err=%0b", c,
                        bus.rsp_addr_o, bus.rsp_slot_o, bus.rsp_err_o, m_rsp.addr, m_rsp.slot, m_rsp.err); end
      total++;
      if (bus.upd_err_o !== m_upd_err || n_free !== 4'(model_free())) begin
        bad++; $display("FAIL rnd_state c=%0d got upd_err=%0b n_free=%0d exp upd_err=%0b n_free=%0d",
                        c, bus.upd_err_o, n_free, m_upd_err, model_free()); end
    end
    clear = 0; set_req(0, SLOT_ALLOC, 0); set_upd(0, SLOT_UPDATE, 0, '0, '0); bus.rsp_ready_i = 1;
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    set_req(0, SLOT_ALLOC, 0);
    set_upd(0, SLOT_UPDATE, 0, '0, '0);
    bus.rsp_ready_i = 1;
    model_reset();
    #23 rst_n = 1;
    #1;
    test_reset();
    tick();
    test_alloc_fill();
    test_update_load();
    test_fwd();
    test_free_alloc_same_cycle();
    test_backpressure_clear();
    test_upd_errors();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
